// File: rtl/vga_pkg.sv
// VGA shared package: timing configuration table, register map constants
// and configurator error codes.
package vga_pkg;

    typedef struct packed {
        logic [15:0] h_res;
        logic [15:0] h_front_porch;
        logic [15:0] h_sync_pulse;
        logic [15:0] h_back_porch;
        logic [15:0] v_res;
        logic [15:0] v_front_porch;
        logic [15:0] v_sync_pulse;
        logic [15:0] v_back_porch;
    } vga_config_t;

    localparam vga_config_t vga_configs [3] = '{
        '{16'd640,  16'd16, 16'd96,  16'd48,  16'd480, 16'd10, 16'd2, 16'd33},
        '{16'd800,  16'd40, 16'd128, 16'd88,  16'd600, 16'd1,  16'd4, 16'd23},
        '{16'd1024, 16'd24, 16'd136, 16'd160, 16'd768, 16'd3,  16'd6, 16'd29}
    };

    localparam logic [11:0] VGA_REG_ID_ADDR     = 12'h000;
    localparam logic [11:0] VGA_REG_TIMING_BASE = 12'h010;
    localparam logic [31:0] VGA_ID_VALUE        = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        OK          = 3'd0,
        BAD_SEL     = 3'd1,
        RESP        = 3'd2,
        ID_MISMATCH = 3'd3,
        TIMEOUT     = 3'd4
    } vga_cfg_err_e;

    function automatic logic [15:0] vga_cfg_field(vga_config_t cfg,
                                                  logic [2:0]  idx);
        logic [15:0] f;
        f = '0;
        unique case (idx)
            3'd0: f = cfg.h_res;
            3'd1: f = cfg.h_front_porch;
            3'd2: f = cfg.h_sync_pulse;
            3'd3: f = cfg.h_back_porch;
            3'd4: f = cfg.v_res;
            3'd5: f = cfg.v_front_porch;
            3'd6: f = cfg.v_sync_pulse;
            3'd7: f = cfg.v_back_porch;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/vga_cfg_if.sv
// AXI4-Lite control bus between the configurator and the VGA
// register block.
interface vga_cfg_if;
    logic        awvalid;
    logic        awready;
    logic [11:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [11:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb,
        output bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb,
        input  bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/vga_cfg_master.sv
// Programs the VGA timing registers from a table entry over AXI4-Lite,
// then optionally reads back and verifies the ID register.
module vga_cfg_master
    import vga_pkg::*;
#(
    parameter int CFG_SEL_W      = 2,
    parameter int VERIFY_ID      = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic [CFG_SEL_W-1:0] cfg_sel,
    output logic                 busy,
    output logic                 done,
    output vga_cfg_err_e         err_code,
    output logic [31:0]          id_value,
    vga_cfg_if.master            ctrl
);

    localparam int NUM_CFG = $size(vga_configs);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_FIN
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [31:0]            tmo_q, tmo_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    vga_cfg_err_e           err_q, err_d;
    logic [31:0]            id_q, id_d;
    logic [CFG_SEL_W-1:0]   sel_q, sel_d;
    vga_config_t            cfg_q, cfg_d;
    logic                   timeout;
    logic                   aw_hs;
    logic                   w_hs;

    assign err_code = err_q;
    assign id_value = id_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        id_d      = id_q;
        sel_d     = sel_q;
        cfg_d     = cfg_q;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        ctrl.awvalid = 1'b0;
        ctrl.awaddr  = '0;
        ctrl.wvalid  = 1'b0;
        ctrl.wdata   = '0;
        ctrl.wstrb   = 4'hF;
        ctrl.bready  = 1'b0;
        ctrl.arvalid = 1'b0;
        ctrl.araddr  = '0;
        ctrl.rready  = 1'b0;

        timeout = (TIMEOUT_CYCLES != 0) &&
                  (tmo_q == 32'(TIMEOUT_CYCLES - 1));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d   = cfg_sel;
                    err_d   = OK;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                if (int'(sel_q) >= NUM_CFG) begin
                    err_d   = BAD_SEL;
                    state_d = S_FIN;
                end else begin
                    for (int i = 0; i < NUM_CFG; i++)
                        if (int'(sel_q) == i) cfg_d = vga_configs[i];
                    idx_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                busy         = 1'b1;
                ctrl.awvalid = !aw_done_q;
                ctrl.wvalid  = !w_done_q;
                ctrl.awaddr  = VGA_REG_TIMING_BASE + {7'd0, idx_q, 2'b00};
                ctrl.wdata   = {16'h0, vga_cfg_field(cfg_q, idx_q)};
                aw_hs        = !aw_done_q && ctrl.awready;
                w_hs         = !w_done_q && ctrl.wready;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_RESP;
                end else begin
                    aw_done_d = aw_done_q || aw_hs;
                    w_done_d  = w_done_q || w_hs;
                    if (timeout) begin
                        err_d   = TIMEOUT;
                        state_d = S_FIN;
                    end
                end
            end
            S_WR_RESP: begin
                busy        = 1'b1;
                ctrl.bready = 1'b1;
                if (ctrl.bvalid) begin
                    if (ctrl.bresp != 2'b00) begin
                        err_d   = RESP;
                        state_d = S_FIN;
                    end else if (idx_q == 3'd7) begin
                        state_d = (VERIFY_ID != 0) ? S_RD_ADDR : S_FIN;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_WR;
                    end
                end else if (timeout) begin
                    err_d   = TIMEOUT;
                    state_d = S_FIN;
                end
            end
            S_RD_ADDR: begin
                busy         = 1'b1;
                ctrl.arvalid = 1'b1;
                ctrl.araddr  = VGA_REG_ID_ADDR;
                if (ctrl.arready) begin
                    state_d = S_RD_DATA;
                end else if (timeout) begin
                    err_d   = TIMEOUT;
                    state_d = S_FIN;
                end
            end
            S_RD_DATA: begin
                busy        = 1'b1;
                ctrl.rready = 1'b1;
                if (ctrl.rvalid) begin
                    id_d = ctrl.rdata;
                    if (ctrl.rresp != 2'b00)
                        err_d = RESP;
                    else if (ctrl.rdata != VGA_ID_VALUE)
                        err_d = ID_MISMATCH;
                    else
                        err_d = OK;
                    state_d = S_FIN;
                end else if (timeout) begin
                    err_d   = TIMEOUT;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Wait counter restarts whenever the state changes.
        tmo_d = (state_d != state_q) ? 32'd0 : tmo_q + 32'd1;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= OK;
            id_q      <= '0;
            sel_q     <= '0;
            cfg_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            id_q      <= id_d;
            sel_q     <= sel_d;
            cfg_q     <= cfg_d;
        end
    end

endmodule

// File: tb/tb_vga_cfg_master.sv
// Directed bench for vga_cfg_master with a reactive AXI4-Lite slave
// model whose wait states and responses are set per step.
module tb_vga_cfg_master;

    logic        clk = 1'b0;
    logic        areset;
    logic        start;
    logic [1:0]  cfg_sel;
    logic        busy;
    logic        done;
    logic [2:0]  err_code;
    logic [31:0] id_value;

    vga_cfg_if ctrl_if();

    vga_cfg_master #(
        .CFG_SEL_W     (2),
        .VERIFY_ID     (1),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk    (clk),
        .areset  (areset),
        .start   (start),
        .cfg_sel (cfg_sel),
        .busy    (busy),
        .done    (done),
        .err_code(err_code),
        .id_value(id_value),
        .ctrl    (ctrl_if.master)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // slave model state
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [11:0] aw_log [8];
    logic [31:0] w_log [8];
    logic [11:0] last_aw;
    logic [11:0] ar_addr_seen;
    int          bad_strb, saw_01c, any_valid, bready_cyc;
    int          stall_cnt, stall_bad, aw_wait;
    bit          mode_awdelay, mode_no_b;
    logic [11:0] bad_b_addr;
    logic [31:0] id_rdata;

    always @(posedge clk) begin
        if (ctrl_if.awvalid && ctrl_if.awready) begin
            if (aw_cnt < 8) aw_log[aw_cnt] = ctrl_if.awaddr;
            if (ctrl_if.awaddr == 12'h01C) saw_01c++;
            last_aw = ctrl_if.awaddr;
            aw_cnt++;
        end
        if (ctrl_if.wvalid && ctrl_if.wready) begin
            if (w_cnt < 8) w_log[w_cnt] = ctrl_if.wdata;
            if (ctrl_if.wstrb != 4'hF) bad_strb++;
            w_cnt++;
        end
        if (ctrl_if.bvalid && ctrl_if.bready) b_cnt++;
        if (ctrl_if.arvalid && ctrl_if.arready) begin
            ar_addr_seen = ctrl_if.araddr;
            ar_cnt++;
        end
        if (ctrl_if.rvalid && ctrl_if.rready) r_cnt++;
    end

    always @(negedge clk) begin
        if (ctrl_if.awvalid || ctrl_if.wvalid || ctrl_if.arvalid)
            any_valid++;
        if (ctrl_if.bready) bready_cyc++;
        if (mode_awdelay && ctrl_if.awvalid &&
            ctrl_if.awaddr == 12'h018 && ctrl_if.wvalid) begin
            ctrl_if.awready = 1'b0;
            ctrl_if.wready  = 1'b1;
            aw_wait = 0;
        end else if (mode_awdelay && ctrl_if.awvalid && !ctrl_if.wvalid) begin
            aw_wait++;
            stall_cnt++;
            if (ctrl_if.awaddr != 12'h018) stall_bad++;
            ctrl_if.awready = (aw_wait >= 3);
            ctrl_if.wready  = 1'b0;
        end else begin
            ctrl_if.awready = ctrl_if.awvalid;
            ctrl_if.wready  = ctrl_if.wvalid;
        end
        ctrl_if.bvalid  = !mode_no_b && (aw_cnt > b_cnt) && (w_cnt > b_cnt);
        ctrl_if.bresp   = (last_aw == bad_b_addr) ? 2'b10 : 2'b00;
        ctrl_if.arready = ctrl_if.arvalid;
        ctrl_if.rvalid  = (ar_cnt > r_cnt);
        ctrl_if.rdata   = id_rdata;
        ctrl_if.rresp   = 2'b00;
    end

    task automatic clear_slave();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        last_aw = 12'hFFF; ar_addr_seen = 12'hFFF;
        bad_strb = 0; saw_01c = 0; any_valid = 0; bready_cyc = 0;
        stall_cnt = 0; stall_bad = 0; aw_wait = 0;
        mode_awdelay = 0; mode_no_b = 0;
        bad_b_addr = 12'hFFF; id_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) begin
            aw_log[i] = '0;
            w_log[i]  = '0;
        end
        ctrl_if.awready = 1'b0; ctrl_if.wready  = 1'b0;
        ctrl_if.bvalid  = 1'b0; ctrl_if.bresp   = 2'b00;
        ctrl_if.arready = 1'b0; ctrl_if.rvalid  = 1'b0;
        ctrl_if.rdata   = '0;   ctrl_if.rresp   = 2'b00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run(input logic [1:0] sel, input int poke,
                       output int cyc, output logic got);
        got = 1'b0;
        cyc = 0;
        start = 1'b1;
        cfg_sel = sel;
        for (int n = 1; n <= 200 && !got; n++) begin
            @(negedge clk);
            start = (n == poke);
            cfg_sel = 2'd3;
            if (done) begin
                got = 1'b1;
                cyc = n;
            end
        end
        start = 1'b0;
    endtask

    logic [11:0] exp_addr [8];
    logic [31:0] exp_cfg1 [8];
    int   cyc;
    logic got;

    initial begin
        exp_addr = '{12'h010, 12'h014, 12'h018, 12'h01C,
                     12'h020, 12'h024, 12'h028, 12'h02C};
        exp_cfg1 = '{32'd800, 32'd40, 32'd128, 32'd88,
                     32'd600, 32'd1, 32'd4, 32'd23};
        areset = 1'b1;
        start = 1'b0;
        cfg_sel = 2'd0;
        clear_slave();
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_awvalid", {31'd0, ctrl_if.awvalid}, 32'd0);
        chk("rst_wstrb", {28'd0, ctrl_if.wstrb}, 32'hF);
        chk("rst_awaddr", {20'd0, ctrl_if.awaddr}, 32'd0);
        areset = 1'b0;
        @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {29'd0, err_code}, 32'd0);
        chk("rst_id", id_value, 32'd0);

        // zero-wait slave, config 1
        run(2'd1, 0, cyc, got);
        chk("t1_done", {31'd0, got}, 32'd1);
        chk("t1_latency", cyc, 32'd20);
        chk("t1_err", {29'd0, err_code}, 32'd0);
        chk("t1_id", id_value, 32'hDEADBEEF);
        chk("t1_aw_cnt", aw_cnt, 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_awaddr%0d", i), {20'd0, aw_log[i]},
                {20'd0, exp_addr[i]});
            chk($sformatf("t1_wdata%0d", i), w_log[i], exp_cfg1[i]);
        end
        chk("t1_wstrb", bad_strb, 32'd0);
        chk("t1_araddr", {20'd0, ar_addr_seen}, 32'd0);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);

        // AW accepted 3 cycles after W on write 2
        @(negedge clk);
        clear_slave();
        mode_awdelay = 1;
        run(2'd0, 0, cyc, got);
        chk("t2_done", {31'd0, got}, 32'd1);
        chk("t2_latency", cyc, 32'd23);
        chk("t2_err", {29'd0, err_code}, 32'd0);
        chk("t2_b_cnt", b_cnt, 32'd8);
        chk("t2_w_cnt", w_cnt, 32'd8);
        chk("t2_stall", stall_cnt, 32'd3);
        chk("t2_stall_addr", stall_bad, 32'd0);
        chk("t2_wdata0", w_log[0], 32'd640);

        // SLVERR on the write to 0x018
        @(negedge clk);
        clear_slave();
        bad_b_addr = 12'h018;
        run(2'd2, 0, cyc, got);
        chk("t3_done", {31'd0, got}, 32'd1);
        chk("t3_latency", cyc, 32'd8);
        chk("t3_err", {29'd0, err_code}, 32'd2);
        chk("t3_aw_cnt", aw_cnt, 32'd3);
        chk("t3_no_01c", saw_01c, 32'd0);

        // wrong ID, with a stray start while busy
        @(negedge clk);
        clear_slave();
        id_rdata = 32'h12345678;
        run(2'd1, 5, cyc, got);
        chk("t4_done", {31'd0, got}, 32'd1);
        chk("t4_latency", cyc, 32'd20);
        chk("t4_err", {29'd0, err_code}, 32'd3);
        chk("t4_id", id_value, 32'h12345678);
        start = 1'b1;
        cfg_sel = 2'd3;
        @(negedge clk);
        start = 1'b0;
        chk("t4_fin_start_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("t4_fin_start_busy2", {31'd0, busy}, 32'd0);
        chk("t4_err_held", {29'd0, err_code}, 32'd3);

        // out-of-range selector
        clear_slave();
        run(2'd3, 0, cyc, got);
        chk("t5_done", {31'd0, got}, 32'd1);
        chk("t5_latency", cyc, 32'd2);
        chk("t5_err", {29'd0, err_code}, 32'd1);
        chk("t5_no_valid", any_valid, 32'd0);

        // no write response ever
        @(negedge clk);
        clear_slave();
        mode_no_b = 1;
        run(2'd0, 0, cyc, got);
        chk("t6_done", {31'd0, got}, 32'd1);
        chk("t6_latency", cyc, 32'd19);
        chk("t6_err", {29'd0, err_code}, 32'd4);
        chk("t6_bready_cyc", bready_cyc, 32'd16);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        clear_slave();
        @(negedge clk);

        // async reset in the middle of a write
        start = 1'b1;
        cfg_sel = 2'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t7_in_wr", {31'd0, ctrl_if.awvalid}, 32'd1);
        #2 areset = 1'b1;
        #1;
        chk("t7_awvalid", {31'd0, ctrl_if.awvalid}, 32'd0);
        chk("t7_wvalid", {31'd0, ctrl_if.wvalid}, 32'd0);
        chk("t7_busy", {31'd0, busy}, 32'd0);
        chk("t7_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        areset = 1'b0;
        clear_slave();
        run(2'd0, 0, cyc, got);
        chk("t7_re_done", {31'd0, got}, 32'd1);
        chk("t7_re_latency", cyc, 32'd20);
        chk("t7_re_err", {29'd0, err_code}, 32'd0);
        chk("t7_re_b_cnt", b_cnt, 32'd8);
        chk("t7_re_wdata7", w_log[7], 32'd33);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
